computer_output_of_verifla: RTL and testbench
=============================================

COMPUTER_OUTPUT_OF_VERIFLA -- requirements
Module: computer_output_of_verifla

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter ADDR_BITS, 8, capture memory address width (1..16).
REQ-003 Parameter MEM_WORD_BYTES, 2, bytes per capture memory word (1..4).
REQ-004 Parameter MEM_LAST_ADDR, 255, highest memory address sent.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 send_start  input  1  one-cycle request to dump memory to the computer.
REQ-008 trig_addr  input  ADDR_BITS  memory address of the trigger event, sampled on accepted send_start.
REQ-009 mem_addr  output  ADDR_BITS  capture memory read address.
REQ-010 mem_data  input  8*MEM_WORD_BYTES  capture memory read data, valid one cycle after mem_addr.
REQ-011 xmit_dataH  output  8  byte to UART transmitter.
REQ-012 xmitH  output  1  one-cycle pulse: UART transmitter loads xmit_dataH.
REQ-013 xmit_doneH  input  1  one-cycle pulse from UART transmitter: current byte fully sent.
REQ-014 send_busy  output  1  high while a dump is in progress.
REQ-015 send_done  output  1  one-cycle pulse after the last byte's xmit_doneH.

Function
REQ-016 States SHALL be IDLE, READ, LATCH, LOAD, WAIT_DONE, TRAILER, FINISH.
REQ-017 IDLE: send_start=1 -> capture trig_addr, word address=0, byte index=0, go READ; send_busy=1 from the next cycle.
REQ-018 READ: drive mem_addr=word address for one cycle -> LATCH.
REQ-019 LATCH: register mem_data into a shift register -> LOAD.
REQ-020 LOAD: xmit_dataH=current byte, most-significant byte of word first; xmitH=1 exactly this one cycle -> WAIT_DONE.
REQ-021 xmit_dataH SHALL stay stable from the LOAD cycle until the matching xmit_doneH.
REQ-022 WAIT_DONE: hold until xmit_doneH=1; then if bytes of word remain -> LOAD (next byte); else if word address<MEM_LAST_ADDR -> increment address, READ; else -> TRAILER.
REQ-023 TRAILER: send trig_addr zero-extended to 16 bits, high byte then low byte, each via the LOAD/WAIT_DONE handshake.
REQ-024 After the low trailer byte's xmit_doneH -> FINISH: send_done=1 one cycle, send_busy=0 from next cycle, -> IDLE.
REQ-025 Total bytes per dump SHALL be (MEM_LAST_ADDR+1)*MEM_WORD_BYTES+2; no byte skipped or repeated.
REQ-026 Minimum spacing between consecutive xmitH pulses SHALL be 2 cycles within a word, 4 across a word boundary.
REQ-027 send_start while send_busy=1 SHALL be ignored; trig_addr SHALL not be resampled.
REQ-028 xmit_doneH outside WAIT_DONE SHALL be ignored.
REQ-029 xmit_doneH in the same cycle as xmitH SHALL not count for that byte.
REQ-030 Word address SHALL not wrap; dump ends exactly at MEM_LAST_ADDR even if MEM_LAST_ADDR=2^ADDR_BITS-1.
REQ-031 Illegal state encoding SHALL return to IDLE next cycle with outputs deasserted.

Reset
REQ-032 While reset=1: state=IDLE, mem_addr=0, xmit_dataH=0, xmitH=0, send_busy=0, send_done=0, counters=0.
REQ-033 reset mid-dump SHALL abort in the next cycle, producing no further xmitH or send_done.
REQ-034 reset and send_start in the same cycle: reset wins, no dump starts.

Verification
REQ-035 ADDR_BITS=2, MEM_WORD_BYTES=2, MEM_LAST_ADDR=3, mem[i]=16'hA0B0+i, trig_addr=2, tx done 5 cycles after each xmitH -> bytes A0 B0 A0 B1 A0 B2 A0 B3 00 02, then one send_done pulse.
REQ-036 Same setup, xmit_doneH held off 100 cycles on byte 3 -> xmit_dataH stays A0 and no xmitH for 100 cycles; stream otherwise identical.
REQ-037 send_start pulsed again at byte 4 -> ignored; exactly 10 bytes, one send_done.
REQ-038 reset asserted after byte 5's xmitH -> xmitH, send_busy, send_done all 0 from next cycle; new send_start restarts at A0 B0.
REQ-039 Spurious xmit_doneH in IDLE and in the xmitH cycle -> no extra bytes, byte order unchanged.
REQ-040 MEM_WORD_BYTES=1, MEM_LAST_ADDR=0, mem[0]=8'h5A, trig_addr=0 -> bytes 5A 00 00, send_done after the third xmit_doneH.

Source files
------------

// File: rtl/computer_output_of_verifla.sv
// Streams the capture memory to a UART one byte at a time, most-significant byte
// of each word first, followed by the 16-bit trigger address as a two-byte trailer.
module computer_output_of_verifla #(
    parameter int ADDR_BITS      = 8,
    parameter int MEM_WORD_BYTES = 2,
    parameter int MEM_LAST_ADDR  = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          send_start,
    input  logic [ADDR_BITS-1:0]          trig_addr,
    output logic [ADDR_BITS-1:0]          mem_addr,
    input  logic [8*MEM_WORD_BYTES-1:0]   mem_data,
    output logic [7:0]                    xmit_dataH,
    output logic                          xmitH,
    input  logic                          xmit_doneH,
    output logic                          send_busy,
    output logic                          send_done
);

    localparam int DW = 8 * MEM_WORD_BYTES;
    localparam logic [ADDR_BITS-1:0] LAST_A    = ADDR_BITS'(MEM_LAST_ADDR);
    localparam logic [2:0]           LAST_BYTE = 3'(MEM_WORD_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        LATCH     = 3'd2,
        LOAD      = 3'd3,
        WAIT_DONE = 3'd4,
        TRAILER   = 3'd5,
        FINISH    = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   waddr_q, waddr_d;
    logic [2:0]             byte_q, byte_d;
    logic [7:0]             xdata_q, xdata_d;
    logic                   xmith_q, xmith_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   trailer_q, trailer_d;
    logic                   trl_lo_q, trl_lo_d;
    logic [DW-1:0]          word_q, word_d;
    logic [ADDR_BITS-1:0]   trig_q, trig_d;
    logic [15:0]            trig16;

    // Byte idx counts from the most-significant end of the word.
    function automatic logic [7:0] byte_of(input logic [DW-1:0] w, input logic [2:0] idx);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < MEM_WORD_BYTES; i++) begin
            if (idx == 3'(MEM_WORD_BYTES - 1 - i)) r = w[8*i +: 8];
        end
        return r;
    endfunction

    assign trig16 = 16'(trig_q);

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        byte_d    = byte_q;
        xdata_d   = xdata_q;
        xmith_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        trailer_d = trailer_q;
        trl_lo_d  = trl_lo_q;
        word_d    = word_q;
        trig_d    = trig_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (send_start) begin
                    trig_d    = trig_addr;
                    waddr_d   = '0;
                    byte_d    = '0;
                    trailer_d = 1'b0;
                    trl_lo_d  = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = READ;
                end
            end
            READ: state_d = LATCH;
            LATCH: begin
                word_d  = mem_data;
                xdata_d = byte_of(mem_data, byte_q);
                xmith_d = 1'b1;
                state_d = LOAD;
            end
            LOAD: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (xmit_doneH) begin
                    if (trailer_q) begin
                        if (!trl_lo_q) begin
                            trl_lo_d = 1'b1;
                            xdata_d  = trig16[7:0];
                            xmith_d  = 1'b1;
                            state_d  = LOAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = FINISH;
                        end
                    end else if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 3'd1;
                        xdata_d = byte_of(word_q, byte_q + 3'd1);
                        xmith_d = 1'b1;
                        state_d = LOAD;
                    end else if (waddr_q != LAST_A) begin
                        // Compare before incrementing so a full-range dump never wraps.
                        waddr_d = waddr_q + 1'b1;
                        byte_d  = '0;
                        state_d = READ;
                    end else begin
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                trailer_d = 1'b1;
                xdata_d   = trig16[15:8];
                xmith_d   = 1'b1;
                state_d   = LOAD;
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                waddr_d   = '0;
                byte_d    = '0;
                trailer_d = 1'b0;
                trl_lo_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            waddr_q   <= '0;
            byte_q    <= '0;
            xdata_q   <= '0;
            xmith_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            trailer_q <= 1'b0;
            trl_lo_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            byte_q    <= byte_d;
            xdata_q   <= xdata_d;
            xmith_q   <= xmith_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            trailer_q <= trailer_d;
            trl_lo_q  <= trl_lo_d;
        end
    end

    // Pure data holding registers; only loaded under FSM control.
    always_ff @(posedge clk) begin
        word_q <= word_d;
        trig_q <= trig_d;
    end

    assign mem_addr   = waddr_q;
    assign xmit_dataH = xdata_q;
    assign xmitH      = xmith_q;
    assign send_busy  = busy_q;
    assign send_done  = done_q;

endmodule

// File: tb/tb_computer_output_of_verifla.sv
// Bench for computer_output_of_verifla: a byte-stream model checks a 4-word/2-byte
// instance every cycle; a 1-word/1-byte instance is checked with directed literals.
module tb_computer_output_of_verifla;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ADDR_BITS=2, MEM_WORD_BYTES=2, MEM_LAST_ADDR=3
    logic        rst_a, start_a, xh_a, xdone_a, busy_a, sdone_a;
    logic [1:0]  trig_a, maddr_a;
    logic [15:0] mdata_a;
    logic [7:0]  xd_a;

    // Instance B: ADDR_BITS=1, MEM_WORD_BYTES=1, MEM_LAST_ADDR=0
    logic        rst_b, start_b, xh_b, xdone_b, busy_b, sdone_b;
    logic [0:0]  trig_b, maddr_b;
    logic [7:0]  mdata_b;
    logic [7:0]  xd_b;

    computer_output_of_verifla #(.ADDR_BITS(2), .MEM_WORD_BYTES(2), .MEM_LAST_ADDR(3)) dut_a (
        .clk(clk), .reset(rst_a), .send_start(start_a), .trig_addr(trig_a),
        .mem_addr(maddr_a), .mem_data(mdata_a), .xmit_dataH(xd_a), .xmitH(xh_a),
        .xmit_doneH(xdone_a), .send_busy(busy_a), .send_done(sdone_a)
    );

    computer_output_of_verifla #(.ADDR_BITS(1), .MEM_WORD_BYTES(1), .MEM_LAST_ADDR(0)) dut_b (
        .clk(clk), .reset(rst_b), .send_start(start_b), .trig_addr(trig_b),
        .mem_addr(maddr_b), .mem_data(mdata_b), .xmit_dataH(xd_b), .xmitH(xh_b),
        .xmit_doneH(xdone_b), .send_busy(busy_b), .send_done(sdone_b)
    );

    // Synchronous-read capture memories
    always @(posedge clk) mdata_a <= 16'hA0B0 + 16'(maddr_a);
    always @(posedge clk) mdata_b <= (maddr_b == 1'b0) ? 8'h5A : 8'hEE;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp035 [10] = '{8'hA0, 8'hB0, 8'hA0, 8'hB1, 8'hA0, 8'hB2, 8'hA0, 8'hB3, 8'h00, 8'h02};

    // Shared between stimulus, UART responder and model
    int   hold_byte = 0;
    bit   spur_xmit = 1'b0;
    int   spur_req  = 0;

    // Model state
    logic [7:0] q[$];
    bit         m_busy, awaiting, fin_due, rst_seen;
    logic [7:0] last_x;
    int         cyc, last_x_cyc, got_n, done_n;
    logic [7:0] got [16];
    int         x_cyc [16];

    // UART transmitter stand-in for instance A
    initial begin : uart_a
        int cnt, n, ack;
        cnt = 0; n = 0; ack = 0;
        xdone_a = 1'b0;
        forever begin
            tick();
            xdone_a = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) xdone_a = 1'b1;
            end
            if (xh_a) begin
                n++;
                cnt = (n == hold_byte) ? 100 : 5;
                if (spur_xmit) xdone_a = 1'b1;
            end
            if (spur_req != ack) begin
                ack = spur_req;
                xdone_a = 1'b1;
            end
            if (!busy_a) begin
                n = 0;
                cnt = 0;
            end
        end
    end

    // Byte-stream model and per-cycle compare for instance A
    initial begin : compare_a
        bit busy_now;
        logic [15:0] w;
        int idx, min_gap;
        rst_seen = 1'b1; m_busy = 1'b0; awaiting = 1'b0; fin_due = 1'b0;
        cyc = 0; last_x_cyc = 0; got_n = 0; done_n = 0; last_x = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_seen) begin
                check("rst_xmitH", xh_a, 0);
                check("rst_send_busy", busy_a, 0);
                check("rst_send_done", sdone_a, 0);
                check("rst_mem_addr", maddr_a, 0);
                check("rst_xmit_data", xd_a, 0);
                m_busy = 1'b0; awaiting = 1'b0; fin_due = 1'b0;
                q.delete();
                busy_now = 1'b0;
            end else begin
                busy_now = m_busy;
                check("send_busy", busy_a, m_busy);
                check("send_done", sdone_a, fin_due);
                if (fin_due) begin
                    fin_due = 1'b0;
                    m_busy = 1'b0;
                    done_n++;
                end
                if (xh_a) begin
                    check("xmitH_expected", q.size() != 0, 1);
                    check("xmitH_after_done", awaiting, 0);
                    if (q.size() != 0) begin
                        idx = got_n;
                        check($sformatf("byte%0d", idx), xd_a, q[0]);
                        void'(q.pop_front());
                        if (idx > 0) begin
                            min_gap = (idx < 8 && idx % 2 == 0) ? 4 : 2;
                            check("xmit_spacing", (cyc - last_x_cyc) >= min_gap, 1);
                        end
                        if (got_n < 16) begin
                            got[got_n] = xd_a;
                            x_cyc[got_n] = cyc;
                        end
                        got_n++;
                    end
                    last_x = xd_a;
                    last_x_cyc = cyc;
                    awaiting = 1'b1;
                end else if (awaiting) begin
                    check("xmit_data_stable", xd_a, last_x);
                    if (xdone_a && !rst_a) begin
                        awaiting = 1'b0;
                        if (q.size() == 0) fin_due = 1'b1;
                    end
                end
            end
            if (!rst_a && start_a && !busy_now) begin
                m_busy = 1'b1;
                awaiting = 1'b0;
                got_n = 0;
                done_n = 0;
                q.delete();
                for (int a = 0; a < 4; a++) begin
                    w = 16'hA0B0 + 16'(a);
                    q.push_back(w[15:8]);
                    q.push_back(w[7:0]);
                end
                q.push_back(8'h00);
                q.push_back({6'b0, trig_a});
            end
            rst_seen = rst_a;
        end
    end

    task automatic start_dump(input logic [1:0] t);
        trig_a = t;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        trig_a = ~t;
        check("busy_after_start", busy_a, 1);
    endtask

    task automatic wait_dump();
        int k;
        k = 0;
        while (done_n == 0 && k < 3000) begin
            tick();
            k++;
        end
        check("dump_completes", done_n != 0, 1);
        repeat (3) tick();
    endtask

    task automatic wait_bytes(input int n);
        int k;
        k = 0;
        while (got_n < n && k < 1000) begin
            tick();
            k++;
        end
        check("bytes_reached", got_n >= n, 1);
    endtask

    task automatic check_stream(input string name);
        check({name, "_count"}, got_n, 10);
        check({name, "_done_pulses"}, done_n, 1);
        for (int i = 0; i < 10; i++) check($sformatf("%s_b%0d", name, i), got[i], exp035[i]);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000 ns");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cntb, nb, dn, third, sdn, sdc;
        logic [7:0] bb [4];
        rst_a = 1'b1; start_a = 1'b0; trig_a = '0;
        rst_b = 1'b1; start_b = 1'b0; trig_b = '0; xdone_b = 1'b0;
        repeat (3) tick();
        check("reset_xmitH_a", xh_a, 0);
        check("reset_busy_a", busy_a, 0);
        check("reset_xmit_data_a", xd_a, 0);
        check("reset_busy_b", busy_b, 0);
        check("reset_xmitH_b", xh_b, 0);
        // reset and send_start together: no dump
        start_a = 1'b1; trig_a = 2'd2;
        tick();
        start_a = 1'b0;
        tick();
        check("rst_vs_start_busy", busy_a, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // basic dump
        start_dump(2'd2);
        wait_dump();
        check_stream("basic");

        // long hold-off on byte 3
        hold_byte = 3;
        start_dump(2'd2);
        wait_dump();
        check_stream("hold");
        check("hold_gap_ge_100", (x_cyc[3] - x_cyc[2]) >= 100, 1);
        hold_byte = 0;

        // send_start while busy is ignored, trig not resampled
        start_dump(2'd2);
        wait_bytes(4);
        trig_a = 2'd1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_dump();
        check_stream("restart_ignored");

        // reset mid-dump
        start_dump(2'd2);
        wait_bytes(5);
        rst_a = 1'b1;
        tick();
        check("abort_xmitH", xh_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", sdone_a, 0);
        rst_a = 1'b0;
        repeat (40) tick();
        check("abort_no_more_bytes", got_n, 5);
        check("abort_no_send_done", done_n, 0);
        start_dump(2'd2);
        wait_dump();
        check_stream("after_abort");

        // spurious xmit_doneH in IDLE and in the xmitH cycle
        spur_req++;
        repeat (4) tick();
        spur_xmit = 1'b1;
        start_dump(2'd2);
        wait_dump();
        check_stream("spurious");
        spur_xmit = 1'b0;

        // single-byte words, single word
        trig_b = 1'b0; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_busy_after_start", busy_b, 1);
        cntb = 0; nb = 0; dn = 0; third = -1; sdn = 0; sdc = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            xdone_b = 1'b0;
            if (sdone_b) begin
                sdn++;
                sdc = k;
            end
            if (cntb > 0) begin
                cntb--;
                if (cntb == 0) begin
                    xdone_b = 1'b1;
                    dn++;
                    if (dn == 3) third = k;
                end
            end
            if (xh_b) begin
                if (nb < 4) bb[nb] = xd_b;
                nb++;
                cntb = 5;
            end
        end
        check("b_byte_count", nb, 3);
        check("b_byte0", bb[0], 8'h5A);
        check("b_byte1", bb[1], 8'h00);
        check("b_byte2", bb[2], 8'h00);
        check("b_send_done_pulses", sdn, 1);
        check("b_send_done_timing", sdc, third + 1);
        check("b_idle_at_end", busy_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
